collision_judge: RTL and testbench

COLLISION_JUDGE -- requirements
Module: collision_judge

---
 rtl/collision_judge.sv | 172 +++++++++++++++++
 tb/tb_collision_judge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_judge.sv
// Game-state judge for the dino runner: detects dino/obstacle overlap, keeps the BCD score
// and best score, and sequences IDLE -> RUN -> HIT -> OVER.
module collision_judge #(
    parameter int unsigned DINO_X     = 80,
    parameter int unsigned DINO_W     = 40,
    parameter int unsigned DINO_H     = 40,
    parameter int unsigned OBST_W     = 20,
    parameter int unsigned OBST_H     = 40,
    parameter int unsigned BIRD_W     = 40,
    parameter int unsigned BIRD_LO    = 50,
    parameter int unsigned BIRD_HI    = 80,
    parameter int unsigned HIT_FRAMES = 3,
    parameter int unsigned SCORE_DIV  = 10,
    parameter int unsigned HIT_HOLD   = 20
) (
    input  logic        clk_10000Hz,
    input  logic        reset,
    input  logic        game_tick,
    input  logic        start,
    input  logic [31:0] x_obst0,
    input  logic [31:0] x_obst1,
    input  logic [31:0] x_obst2,
    input  logic [31:0] x_bird_obst0,
    input  logic [31:0] x_bird_obst1,
    input  logic [9:0]  y_dino,
    output logic        enable,
    output logic        obst_reset,
    output logic        game_over,
    output logic        hit_flash,
    output logic [15:0] score,
    output logic [15:0] hi_score
);

    typedef enum logic [1:0] {StIdle, StRun, StHit, StOver} state_e;

    localparam logic [15:0] TickLast = 16'(SCORE_DIV - 1);
    localparam logic [15:0] HitLast  = 16'(HIT_FRAMES - 1);
    localparam logic [15:0] HoldLast = 16'(HIT_HOLD - 1);

    state_e      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [15:0] hi_score_q, hi_score_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        obst_reset_q, obst_reset_d;

    logic [32:0] y_ext;
    logic        ground_y, bird_y, hit_now;

    // 33-bit compare so a far-right obstacle plus its width can never wrap into the dino.
    function automatic logic x_overlap(input logic [31:0] x, input logic [32:0] w);
        return ({1'b0, x} < 33'(DINO_X + DINO_W)) && (({1'b0, x} + w) > 33'(DINO_X));
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign y_ext    = {23'b0, y_dino};
    assign ground_y = y_ext < 33'(OBST_H);
    assign bird_y   = (y_ext < 33'(BIRD_HI)) && ((y_ext + 33'(DINO_H)) > 33'(BIRD_LO));

    assign hit_now = (ground_y && (x_overlap(x_obst0, 33'(OBST_W)) ||
                                   x_overlap(x_obst1, 33'(OBST_W)) ||
                                   x_overlap(x_obst2, 33'(OBST_W)))) ||
                     (bird_y && (x_overlap(x_bird_obst0, 33'(BIRD_W)) ||
                                 x_overlap(x_bird_obst1, 33'(BIRD_W))));

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        hi_score_d   = hi_score_q;
        tick_cnt_d   = tick_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        obst_reset_d = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                // A coincident game_tick is deliberately dropped here.
                if (start) begin
                    state_d      = StRun;
                    score_d      = 16'h0000;
                    tick_cnt_d   = 16'd0;
                    hit_cnt_d    = 16'd0;
                    hold_cnt_d   = 16'd0;
                    obst_reset_d = 1'b1;
                end
            end
            StRun: begin
                if (game_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = 16'd0;
                        score_d    = bcd_inc(score_q);
                    end else begin
                        tick_cnt_d = tick_cnt_q + 16'd1;
                    end

                    if (!hit_now) begin
                        hit_cnt_d = 16'd0;
                    end else if (hit_cnt_q == HitLast) begin
                        hit_cnt_d  = 16'd0;
                        hold_cnt_d = 16'd0;
                        state_d    = StHit;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
                end
            end
            StHit: begin
                if (game_tick) begin
                    if (hold_cnt_q == HoldLast) begin
                        hold_cnt_d = 16'd0;
                        state_d    = StOver;
                        // Packed BCD orders the same as the decimal value.
                        if (score_q > hi_score_q) begin
                            hi_score_d = score_q;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_10000Hz) begin
        if (!reset) begin
            state_q      <= StIdle;
            score_q      <= 16'h0000;
            hi_score_q   <= 16'h0000;
            tick_cnt_q   <= 16'd0;
            hit_cnt_q    <= 16'd0;
            hold_cnt_q   <= 16'd0;
            obst_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            hi_score_q   <= hi_score_d;
            tick_cnt_q   <= tick_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            obst_reset_q <= obst_reset_d;
        end
    end

    assign enable     = (state_q == StRun);
    assign hit_flash  = (state_q == StHit);
    assign game_over  = (state_q == StOver);
    assign obst_reset = obst_reset_q;
    assign score      = score_q;
    assign hi_score   = hi_score_q;

endmodule

// File: tb/tb_collision_judge.sv
// Bench for collision_judge: geometry vector table, directed game sequences and a randomized
// run, all checked against a decimal-arithmetic model of the game rules.
module tb_collision_judge;

    localparam int     SDIV = 3;
    localparam longint DX = 80, DW = 40, DH = 40, OW = 20, OH = 40;
    localparam longint BW = 40, BLO = 50, BHI = 80;
    localparam int     HF = 3, HH = 20;
    localparam logic [31:0] FAR = 32'd2000;

    logic        clk = 1'b0;
    logic        reset, game_tick, start;
    logic [31:0] x0, x1, x2, b0, b1;
    logic [9:0]  y;
    logic        enable, obst_reset, game_over, hit_flash;
    logic [15:0] score, hi_score;

    int checks = 0;
    int errors = 0;

    collision_judge #(.SCORE_DIV(SDIV)) dut (
        .clk_10000Hz (clk),
        .reset       (reset),
        .game_tick   (game_tick),
        .start       (start),
        .x_obst0     (x0),
        .x_obst1     (x1),
        .x_obst2     (x2),
        .x_bird_obst0(b0),
        .x_bird_obst1(b1),
        .y_dino      (y),
        .enable      (enable),
        .obst_reset  (obst_reset),
        .game_over   (game_over),
        .hit_flash   (hit_flash),
        .score       (score),
        .hi_score    (hi_score)
    );

    always #50 clk = ~clk;

    // Model: 0 idle, 1 run, 2 hit, 3 over; score kept as a plain decimal integer.
    int m_state, m_run_ticks, m_streak, m_hold, m_score, m_hi;
    bit m_or;

    function automatic bit in_x(input logic [31:0] x, input longint w);
        longint xl;
        xl = {32'b0, x};
        return (xl < DX + DW) && (xl + w > DX);
    endfunction

    function automatic bit hit_model();
        longint yl;
        bit gy, by;
        yl = {54'b0, y};
        gy = yl < OH;
        by = (yl < BHI) && (yl + DH > BLO);
        return (gy && (in_x(x0, OW) || in_x(x1, OW) || in_x(x2, OW))) ||
               (by && (in_x(b0, BW) || in_x(b1, BW)));
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_update();
        bit h;
        h    = hit_model();
        m_or = 1'b0;
        if (!reset) begin
            m_state = 0; m_run_ticks = 0; m_streak = 0; m_hold = 0; m_score = 0; m_hi = 0;
            return;
        end
        case (m_state)
            0, 3: if (start) begin
                m_state = 1; m_run_ticks = 0; m_streak = 0; m_score = 0; m_or = 1'b1;
            end
            1: if (game_tick) begin
                m_run_ticks++;
                m_score  = (m_run_ticks / SDIV > 9999) ? 9999 : m_run_ticks / SDIV;
                m_streak = h ? m_streak + 1 : 0;
                if (m_streak == HF) begin
                    m_state = 2; m_hold = 0; m_streak = 0;
                end
            end
            2: if (game_tick) begin
                m_hold++;
                if (m_hold == HH) begin
                    m_state = 3;
                    if (m_score > m_hi) m_hi = m_score;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("enable", 16'(enable), 16'(m_state == 1));
        chk("obst_reset", 16'(obst_reset), 16'(m_or));
        chk("hit_flash", 16'(hit_flash), 16'(m_state == 2));
        chk("game_over", 16'(game_over), 16'(m_state == 3));
        chk("score", score, to_bcd(m_score));
        chk("hi_score", hi_score, to_bcd(m_hi));
    endtask

    task automatic cyc(input bit t, input bit s, input bit r);
        game_tick = t;
        start     = s;
        reset     = r;
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic place(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] c0, input logic [31:0] c1, input logic [9:0] yy);
        x0 = a0; x1 = a1; x2 = a2; b0 = c0; b1 = c1; y = yy;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
    endtask

    // Run, collide for HIT_FRAMES ticks, then hold in HIT until OVER.
    task automatic crash_to_over();
        place(32'd90, FAR, FAR, FAR, FAR, 10'd0);
        ticks(HF);
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);
        ticks(HH);
    endtask

    typedef struct {
        logic [31:0] a0, a1, a2, c0, c1;
        logic [9:0]  yy;
        bit          hit;
    } vec_t;

    vec_t vt[$];

    initial begin
        reset = 1'b0; game_tick = 1'b0; start = 1'b0;
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);

        vt.push_back('{32'd90, FAR, FAR, FAR, FAR, 10'd0, 1'b1});
        vt.push_back('{32'd60, FAR, FAR, FAR, FAR, 10'd0, 1'b0});
        vt.push_back('{32'd61, FAR, FAR, FAR, FAR, 10'd0, 1'b1});
        vt.push_back('{32'd119, FAR, FAR, FAR, FAR, 10'd0, 1'b1});
        vt.push_back('{32'd120, FAR, FAR, FAR, FAR, 10'd0, 1'b0});
        vt.push_back('{32'd90, FAR, FAR, FAR, FAR, 10'd40, 1'b0});
        vt.push_back('{32'd90, FAR, FAR, FAR, FAR, 10'd39, 1'b1});
        vt.push_back('{FAR, 32'd90, FAR, FAR, FAR, 10'd0, 1'b1});
        vt.push_back('{FAR, FAR, 32'd100, FAR, FAR, 10'd0, 1'b1});
        vt.push_back('{FAR, FAR, FAR, 32'd90, FAR, 10'd0, 1'b0});
        vt.push_back('{FAR, FAR, FAR, 32'd90, FAR, 10'd20, 1'b1});
        vt.push_back('{FAR, FAR, FAR, FAR, 32'd90, 10'd10, 1'b0});
        vt.push_back('{FAR, FAR, FAR, FAR, 32'd90, 10'd11, 1'b1});
        vt.push_back('{FAR, FAR, FAR, 32'd90, FAR, 10'd79, 1'b1});
        vt.push_back('{FAR, FAR, FAR, 32'd90, FAR, 10'd80, 1'b0});
        vt.push_back('{FAR, FAR, FAR, 32'd41, FAR, 10'd20, 1'b1});
        vt.push_back('{FAR, FAR, FAR, 32'd40, FAR, 10'd20, 1'b0});
        vt.push_back('{32'hFFFF_FFF0, FAR, FAR, 32'hFFFF_FFE0, FAR, 10'd20, 1'b0});
        vt.push_back('{FAR, FAR, FAR, FAR, FAR, 10'd0, 1'b0});

        // Reset state and IDLE ignoring ticks.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_enable", 16'(enable), 16'd0);
        chk("rst_score", score, 16'h0000);
        ticks(5);
        chk("idle_enable", 16'(enable), 16'd0);
        chk("idle_score", score, 16'h0000);

        // Start pulse, one-cycle obst_reset, start in RUN ignored.
        cyc(1'b0, 1'b1, 1'b1);
        chk("start_enable", 16'(enable), 16'd1);
        chk("start_obst_reset", 16'(obst_reset), 16'd1);
        chk("start_score", score, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1);
        chk("obst_reset_drop", 16'(obst_reset), 16'd0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("run_start_ignored", 16'(obst_reset), 16'd0);

        // Interrupted overlap streak must not hit.
        place(32'd90, FAR, FAR, FAR, FAR, 10'd0); ticks(1);
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);    ticks(1);
        place(32'd90, FAR, FAR, FAR, FAR, 10'd0); ticks(2);
        chk("streak_broken", 16'(hit_flash), 16'd0);
        ticks(1);
        chk("streak_hit", 16'(hit_flash), 16'd1);

        // HIT ignores start; OVER only after HIT_HOLD ticks, with idle cycles between.
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("hit_start_ignored", 16'(hit_flash), 16'd1);
        for (int i = 0; i < HH - 1; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        chk("hold_not_over", 16'(game_over), 16'd0);
        ticks(1);
        chk("hold_over", 16'(game_over), 16'd1);

        // Geometry table.
        foreach (vt[i]) begin
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b1);
            place(vt[i].a0, vt[i].a1, vt[i].a2, vt[i].c0, vt[i].c1, vt[i].yy);
            ticks(HF);
            chk($sformatf("table_hit[%0d]", i), 16'(hit_flash), 16'(vt[i].hit));
        end

        // Coincident start+tick in IDLE is not counted.
        cyc(1'b0, 1'b0, 1'b0);
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);
        cyc(1'b1, 1'b1, 1'b1);
        ticks(SDIV - 1);
        chk("idle_coincide_score0", score, 16'h0000);
        ticks(1);
        chk("idle_coincide_score1", score, 16'h0001);

        // Best score kept when a later game scores lower.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);
        ticks(150);
        crash_to_over();
        chk("first_hi", hi_score, 16'h0051);
        ticks(7);
        chk("over_score_held", score, 16'h0051);
        cyc(1'b0, 1'b1, 1'b1);
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);
        ticks(36);
        chk("second_score", score, 16'h0012);
        crash_to_over();
        chk("second_over_score", score, 16'h0013);
        chk("hi_kept", hi_score, 16'h0051);
        cyc(1'b1, 1'b1, 1'b1);
        chk("over_coincide_enable", 16'(enable), 16'd1);
        chk("over_coincide_score", score, 16'h0000);
        chk("over_coincide_obst_reset", 16'(obst_reset), 16'd1);
        ticks(SDIV - 1);
        chk("over_coincide_ignored", score, 16'h0000);

        // Reset mid-RUN, then reset in HIT clears best score too.
        ticks(10);
        cyc(1'b1, 1'b0, 1'b0);
        chk("run_reset_enable", 16'(enable), 16'd0);
        chk("run_reset_score", score, 16'h0000);
        chk("run_reset_hi", hi_score, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1);
        ticks(9);
        place(32'd90, FAR, FAR, FAR, FAR, 10'd0);
        ticks(HF);
        crash_to_over();
        cyc(1'b0, 1'b1, 1'b1);
        place(32'd90, FAR, FAR, FAR, FAR, 10'd0);
        ticks(HF);
        chk("pre_reset_hit", 16'(hit_flash), 16'd1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("hit_reset_flash", 16'(hit_flash), 16'd0);
        chk("hit_reset_over", 16'(game_over), 16'd0);
        chk("hit_reset_hi", hi_score, 16'h0000);

        // Score saturation at 9999.
        cyc(1'b0, 1'b1, 1'b1);
        place(FAR, FAR, FAR, FAR, FAR, 10'd0);
        ticks(SDIV * 9999 + 2 * SDIV);
        chk("sat_score", score, 16'h9999);
        crash_to_over();
        chk("sat_over", 16'(game_over), 16'd1);
        chk("sat_hi", hi_score, 16'h9999);

        // Randomized play against the model.
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            x0 = ($urandom_range(0, 3) == 0) ? FAR : 32'($urandom_range(30, 140));
            x1 = ($urandom_range(0, 3) == 0) ? FAR : 32'($urandom_range(30, 140));
            x2 = ($urandom_range(0, 3) == 0) ? FAR : 32'($urandom_range(30, 140));
            b0 = ($urandom_range(0, 3) == 0) ? FAR : 32'($urandom_range(30, 140));
            b1 = ($urandom_range(0, 3) == 0) ? FAR : 32'($urandom_range(30, 140));
            y  = 10'($urandom_range(0, 100));
            cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 700) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
